fc_accumulate: RTL and testbench
================================

# fc_accumulate

Fully-connected layer accumulator for the forward-propagation datapath; sits directly downstream of the weight streamer. It requests a weight stream with a one-cycle start pulse, fetches one input activation per cycle, and forms N_OUT parallel dot products over K_IN terms. It then applies optional ReLU and saturation, and presents the layer result with a done pulse. One instance serves each layer: 784→128 and 128→10.

## Interface
- N_OUT, 128, number of parallel neurons (lanes)
- K_IN, 784, number of input terms per dot product
- DW, 32, signed data width of weights, activations and outputs
- FRAC, 16, fractional bits; each product is arithmetically shifted right by FRAC
- RELU, 1, 1 = clamp negative results to 0 before saturation
- clka  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- start  input  1  layer request; a one-cycle pulse, sampled only in IDLE
- w_start  output  1  one-cycle pulse to the weight streamer's start input
- w_in  input  N_OUT×DW  weight row from the streamer, one row per cycle
- x_addr  output  clog2(K_IN)  activation memory read address
- x_in  input  DW  activation data; the memory has 1-cycle read latency
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse; y_out is valid from this cycle
- y_out  output  N_OUT×DW  layer result; holds until the next done

## Operation
- States: IDLE → REQ → ACC → FIN → DONE → IDLE.
- **IDLE**
  - start=1 → REQ.
- **REQ** (1 cycle)
  - w_start=1, x_addr=0.
  - All accumulators cleared to 0.
  - Term counter k cleared to 0.
- **ACC** (exactly K_IN cycles, k=0..K_IN-1)
  - Row k of w_in and x_in=x[k] are both valid in this cycle.
  - For each lane i: acc[i] += (w_in[i]·x_in) >>> FRAC.
  - x_addr = k+1 while k<K_IN-1, else holds.
  - At k=K_IN-1 → FIN.
- **FIN** (1 cycle)
  - r = RELU && acc[i]<0 ? 0 : acc[i].
  - Saturate r to [−2^(DW−1), 2^(DW−1)−1].
  - Register the result into y_out[i].
- **DONE** (1 cycle)
  - done=1, then → IDLE.
- Arithmetic:
  - Product is full 2·DW signed; the shift is arithmetic (floor, no rounding).
  - The shifted product is truncated to AW=DW+16 signed bits.
  - Accumulator is AW bits and wraps mod 2^AW; saturation applies only at FIN.
- Boundary conditions:
  - start outside IDLE is ignored (no queueing, no second w_start).
  - The weight streamer must not be restarted by any other master while busy.
  - rst=0 at any time: immediate return to IDLE; the run is abandoned and no done is produced.
  - After reset the next start begins a clean run.
- Reset values: w_start=0, x_addr=0, busy=0, done=0, y_out=0, all acc=0, k=0, state IDLE.

## Timing
- start high in cycle S.
  - REQ in S+1 (w_start high, x_addr=0).
  - ACC in S+2 .. S+K_IN+1.
  - FIN in S+K_IN+2.
  - done high in S+K_IN+3.
- Total latency from start to done: K_IN+3 cycles (787 for the default configuration).
- Alignment contract:
  - The weight streamer presents row k in cycle (w_start cycle)+1+k.
  - x_addr=k issued in cycle S+1+k returns x[k] in S+2+k.
  - Both rows and activations therefore arrive in ACC cycle k.
- Earliest restart: start in the DONE cycle is ignored (state is not IDLE). The earliest accepted start is S+K_IN+4.
- busy is high S+1 .. S+K_IN+3 inclusive.

## Test plan
- **Reset:** hold rst=0 with random inputs → all outputs 0. Release, no start for 20 cycles → busy=0, done never asserts.
- **Basic run:** N_OUT=2, K_IN=4, FRAC=0, RELU=1, x=[1,2,3,4], all w=1520, start in S.
  - w_start in S+1 only; x_addr 0,1,2,3 in S+1..S+4.
  - done in S+7 only, with y_out={15200,15200}.
- **Sign/ReLU:** as the basic run, lane 1 w=−5.
  - RELU=1 → y_out[1]=0.
  - RELU=0 → y_out[1]=−50.
  - Lane 0 stays at 15200 in both cases.
- **Saturation:** FRAC=0, x=2^30 for all 4 terms, w=4 → y_out=0x7FFFFFFF. With w=−4 and RELU=0 → y_out=0x80000000.
- **Fixed point:** FRAC=16, x=0x00018000 (1.5), w=0x00020000 (2.0), K_IN=4 → y_out=0x000C0000 (12.0). With w=0xFFFF0000 (−1.0), x=0x00000001 → each term floors to −1, y_out=−4 (RELU=0).
- **Protocol abuse:**
  - start pulses during ACC and during DONE → ignored, single w_start, result identical to the basic run.
  - rst=0 mid-ACC → outputs 0 immediately, no done.
  - A new start after release → correct result, done at +7.

Source files
------------

// File: rtl/fc_accumulate.sv
// fc_accumulate: fully-connected layer accumulator.
//
// Purpose: after a one-cycle start request, pulses w_start to the weight
// streamer. It then walks the activation memory one address per cycle and
// forms N_OUT parallel fixed-point dot products over K_IN terms. Each result
// gets an optional ReLU and saturation, and the layer result is presented
// with a one-cycle done pulse.
//
// Ports:
//   clka    - clock, all state changes on the rising edge
//   rst     - asynchronous active-low reset
//   start   - layer request pulse, only honoured in IDLE
//   w_start - one-cycle pulse that starts the weight streamer
//   w_in    - one weight row (N_OUT lanes x DW) per ACC cycle
//   x_addr  - activation memory read address (1-cycle read latency)
//   x_in    - activation data for the address issued in the previous cycle
//   busy    - high whenever the block is not IDLE
//   done    - one-cycle pulse; y_out is valid from this cycle on
//   y_out   - layer result (N_OUT lanes x DW); holds until the next done
module fc_accumulate #(
  parameter int N_OUT = 128,
  parameter int K_IN  = 784,
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int RELU  = 1,
  localparam int XW   = (K_IN > 1) ? $clog2(K_IN) : 1
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  start,
  output logic                  w_start,
  input  logic [N_OUT*DW-1:0]   w_in,
  output logic [XW-1:0]         x_addr,
  input  logic signed [DW-1:0]  x_in,
  output logic                  busy,
  output logic                  done,
  output logic [N_OUT*DW-1:0]   y_out
);

  // Accumulator width: headroom above DW so that saturation only happens
  // once, at the end of the run.
  localparam int AW = DW + 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACC  = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [XW-1:0] K_LAST = XW'(K_IN - 1);

  logic [2:0]    state_reg;
  logic [XW-1:0] k_reg;
  logic [XW-1:0] x_addr_reg;
  logic [31:0]   k_ext;

  assign k_ext   = 32'(k_reg);
  assign w_start = (state_reg == S_REQ);
  assign busy    = (state_reg != S_IDLE);
  assign done    = (state_reg == S_DONE);
  assign x_addr  = x_addr_reg;

  // Control FSM. x_addr is registered one step ahead of k: during ACC cycle k
  // it already shows k+1, so the memory's one-cycle latency delivers x[k+1]
  // exactly when the weight row k+1 arrives.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      k_reg      <= '0;
      x_addr_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg  <= S_REQ;
            x_addr_reg <= '0;
          end
        end
        S_REQ: begin
          k_reg     <= '0;
          state_reg <= S_ACC;
          if (K_IN > 1) begin
            x_addr_reg <= XW'(1);
          end
        end
        S_ACC: begin
          // Address for the term after next; holds at K_IN-1 once reached.
          if (k_ext + 32'd2 <= 32'(K_IN - 1)) begin
            x_addr_reg <= XW'(k_ext + 32'd2);
          end
          if (k_reg == K_LAST) begin
            state_reg <= S_FIN;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        S_FIN:   state_reg <= S_DONE;
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Per-lane datapath: multiply, arithmetic shift, accumulate, then ReLU and
  // saturation into the output register at FIN.
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_lane
      logic signed [DW-1:0]   w_lane;
      logic signed [2*DW-1:0] prod;
      logic signed [AW-1:0]   term;
      logic signed [AW-1:0]   acc_reg;
      logic signed [AW-1:0]   relu_val;
      logic [DW-1:0]          sat_val;
      logic [DW-1:0]          y_reg;
      logic                   fits;

      assign w_lane = w_in[gi*DW +: DW];
      // Sign-extend both operands so the low 2*DW bits of the product are
      // the exact signed product.
      assign prod = {{DW{w_lane[DW-1]}}, w_lane} * {{DW{x_in[DW-1]}}, x_in};
      // Floor shift, then truncate to the accumulator width.
      assign term = AW'(prod >>> FRAC);

      assign relu_val = ((RELU != 0) && acc_reg[AW-1]) ? '0 : acc_reg;
      // The value fits in DW bits when every bit above the DW sign bit
      // matches that sign bit.
      assign fits    = (relu_val[AW-1:DW-1] == {(AW-DW+1){relu_val[DW-1]}});
      assign sat_val = fits ? relu_val[DW-1:0]
                     : (relu_val[AW-1] ? {1'b1, {(DW-1){1'b0}}}
                                       : {1'b0, {(DW-1){1'b1}}});

      always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
          acc_reg <= '0;
          y_reg   <= '0;
        end else begin
          if (state_reg == S_REQ) begin
            acc_reg <= '0;
          end else if (state_reg == S_ACC) begin
            acc_reg <= acc_reg + term;
          end
          if (state_reg == S_FIN) begin
            y_reg <= sat_val;
          end
        end
      end

      assign y_out[gi*DW +: DW] = y_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fc_accumulate.sv
// Directed testbench for fc_accumulate with N_OUT=2, K_IN=4.
// Three instances share all stimulus and differ only in FRAC/RELU:
//   dut_a: FRAC=0,  RELU=1
//   dut_b: FRAC=0,  RELU=0
//   dut_c: FRAC=16, RELU=0
// Includes a weight-streamer model (row k in w_start cycle + 1 + k) and a
// 1-cycle-latency activation memory model per instance.
module tb_fc_accumulate;
  localparam int N  = 2;
  localparam int K  = 4;
  localparam int DW = 32;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic          rst;
  logic          start;
  logic [N*DW-1:0] w_in;
  logic [DW-1:0] x_mem [K];
  logic [DW-1:0] w_lane0, w_lane1;
  logic          w_act = 1'b0;
  logic [1:0]    w_row = 2'd0;

  logic          ws_a, ws_b, ws_c;
  logic [1:0]    xa_a, xa_b, xa_c;
  logic [DW-1:0] xi_a, xi_b, xi_c;
  logic          busy_a, busy_b, busy_c;
  logic          done_a, done_b, done_c;
  logic [N*DW-1:0] y_a, y_b, y_c;

  int checks = 0;
  int errors = 0;

  fc_accumulate #(.N_OUT(N), .K_IN(K), .DW(DW), .FRAC(0), .RELU(1)) dut_a (
    .clka(clka), .rst(rst), .start(start), .w_start(ws_a), .w_in(w_in),
    .x_addr(xa_a), .x_in(xi_a), .busy(busy_a), .done(done_a), .y_out(y_a));

  fc_accumulate #(.N_OUT(N), .K_IN(K), .DW(DW), .FRAC(0), .RELU(0)) dut_b (
    .clka(clka), .rst(rst), .start(start), .w_start(ws_b), .w_in(w_in),
    .x_addr(xa_b), .x_in(xi_b), .busy(busy_b), .done(done_b), .y_out(y_b));

  fc_accumulate #(.N_OUT(N), .K_IN(K), .DW(DW), .FRAC(16), .RELU(0)) dut_c (
    .clka(clka), .rst(rst), .start(start), .w_start(ws_c), .w_in(w_in),
    .x_addr(xa_c), .x_in(xi_c), .busy(busy_c), .done(done_c), .y_out(y_c));

  // Weight streamer model: K rows following the w_start pulse; outside the
  // row window the bus carries a junk pattern.
  always @(posedge clka) begin
    if (ws_a) begin
      w_act <= 1'b1;
      w_row <= 2'd0;
    end else if (w_act) begin
      w_row <= w_row + 2'd1;
      if (w_row == 2'(K - 1)) w_act <= 1'b0;
    end
  end
  assign w_in = w_act ? {w_lane1, w_lane0} : {2{32'h0BAD0001}};

  // Activation memories, one registered read port per instance.
  always @(posedge clka) begin
    xi_a <= x_mem[xa_a];
    xi_b <= x_mem[xa_b];
    xi_c <= x_mem[xa_c];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_x(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                       input logic [DW-1:0] x2, input logic [DW-1:0] x3);
    x_mem[0] = x0; x_mem[1] = x1; x_mem[2] = x2; x_mem[3] = x3;
  endtask

  // One run starting at a negedge. Observation j is cycle S+j.
  task automatic run(input string tag, input bit abuse);
    int ws_cnt   = 0;
    int ws_first = -1;
    int done_cnt = 0;
    int done_at  = -1;
    @(negedge clka);
    start = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clka);
      start = abuse && (j == 3 || j == 7);
      if (ws_a) begin
        ws_cnt++;
        if (ws_first < 0) ws_first = j;
      end
      if (done_a) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (j <= 4) chk({tag, " x_addr"}, 64'(xa_a), 64'(j - 1));
      if (j == 7) chk({tag, " busy_in_done"}, 64'(busy_a), 64'd1);
      if (j == 8) chk({tag, " busy_after"}, 64'(busy_a), 64'd0);
    end
    start = 1'b0;
    chk({tag, " w_start_count"}, 64'(ws_cnt), 64'd1);
    chk({tag, " w_start_cycle"}, 64'(ws_first), 64'd1);
    chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, " done_cycle"}, 64'(done_at), 64'd7);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    int done_seen;

    // Reset held with random inputs: every output must stay at zero.
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clka);
      start   = 1'($urandom);
      w_lane0 = $urandom;
      w_lane1 = $urandom;
      set_x($urandom, $urandom, $urandom, $urandom);
      chk("rst_ctrl", 64'({ws_a, xa_a, busy_a, done_a, ws_b, xa_b, busy_b, done_b,
                           ws_c, xa_c, busy_c, done_c}), 64'd0);
      chk("rst_y", y_a | y_b | y_c, 64'd0);
    end

    // Release, no start for 20 cycles.
    @(negedge clka);
    start = 1'b0;
    rst = 1'b1;
    busy_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clka);
      if (busy_a) busy_seen++;
      if (done_a) done_seen++;
    end
    chk("idle_busy", 64'(busy_seen), 64'd0);
    chk("idle_done", 64'(done_seen), 64'd0);

    // Basic run: x=[1,2,3,4], w=1520 -> 10*1520 = 15200.
    set_x(32'd1, 32'd2, 32'd3, 32'd4);
    w_lane0 = 32'd1520;
    w_lane1 = 32'd1520;
    run("basic", 1'b0);
    chk("basic a0", 64'(y_a[31:0]),  64'd15200);
    chk("basic a1", 64'(y_a[63:32]), 64'd15200);
    chk("basic b1", 64'(y_b[63:32]), 64'd15200);
    chk("basic c0", 64'(y_c[31:0]),  64'd0);

    // Sign/ReLU: lane 1 w=-5 -> -50; FRAC=16 floors each term to -1.
    w_lane1 = 32'hFFFFFFFB;
    run("sign", 1'b0);
    chk("sign a0", 64'(y_a[31:0]),  64'd15200);
    chk("sign a1", 64'(y_a[63:32]), 64'd0);
    chk("sign b0", 64'(y_b[31:0]),  64'd15200);
    chk("sign b1", 64'(y_b[63:32]), 64'hFFFFFFCE);
    chk("sign c1", 64'(y_c[63:32]), 64'hFFFFFFFC);

    // Saturation: 4 * (2^30 * 4) = 2^34.
    set_x(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
    w_lane0 = 32'd4;
    w_lane1 = 32'd4;
    run("sat_pos", 1'b0);
    chk("sat_pos a0", 64'(y_a[31:0]),  64'h7FFFFFFF);
    chk("sat_pos b1", 64'(y_b[63:32]), 64'h7FFFFFFF);
    chk("sat_pos c0", 64'(y_c[31:0]),  64'h00040000);
    w_lane0 = 32'hFFFFFFFC;
    w_lane1 = 32'hFFFFFFFC;
    run("sat_neg", 1'b0);
    chk("sat_neg b0", 64'(y_b[31:0]),  64'h80000000);
    chk("sat_neg a0", 64'(y_a[31:0]),  64'd0);
    chk("sat_neg c1", 64'(y_c[63:32]), 64'hFFFC0000);

    // Fixed point: 1.5 * 2.0 * 4 = 12.0.
    set_x(32'h00018000, 32'h00018000, 32'h00018000, 32'h00018000);
    w_lane0 = 32'h00020000;
    w_lane1 = 32'h00020000;
    run("fix", 1'b0);
    chk("fix c0", 64'(y_c[31:0]),  64'h000C0000);
    chk("fix c1", 64'(y_c[63:32]), 64'h000C0000);
    chk("fix a0", 64'(y_a[31:0]),  64'h7FFFFFFF);
    // -1.0 * 1 LSB floors to -1 per term.
    set_x(32'd1, 32'd1, 32'd1, 32'd1);
    w_lane0 = 32'hFFFF0000;
    w_lane1 = 32'hFFFF0000;
    run("floor", 1'b0);
    chk("floor c0", 64'(y_c[31:0]), 64'hFFFFFFFC);
    chk("floor b0", 64'(y_b[31:0]), 64'hFFFC0000);
    chk("floor a0", 64'(y_a[31:0]), 64'd0);

    // Protocol abuse: start pulses during ACC and DONE are ignored.
    set_x(32'd1, 32'd2, 32'd3, 32'd4);
    w_lane0 = 32'd1520;
    w_lane1 = 32'd1520;
    run("abuse", 1'b1);
    chk("abuse a0", 64'(y_a[31:0]),  64'd15200);
    chk("abuse a1", 64'(y_a[63:32]), 64'd15200);

    // Reset in the middle of ACC: immediate return to idle, no done.
    @(negedge clka);
    start = 1'b1;
    @(negedge clka);
    start = 1'b0;
    @(negedge clka);
    @(negedge clka);
    chk("midrst busy_before", 64'(busy_a), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst ctrl", 64'({ws_a, xa_a, busy_a, done_a}), 64'd0);
    chk("midrst y", y_a, 64'd0);
    @(negedge clka);
    @(negedge clka);
    rst = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clka);
      if (done_a) done_seen++;
      if (busy_a) busy_seen++;
    end
    chk("midrst no_done", 64'(done_seen), 64'd0);
    chk("midrst no_busy", 64'(busy_seen), 64'd0);

    // Clean run after the reset.
    w_lane1 = 32'hFFFFFFFB;
    run("after_rst", 1'b0);
    chk("after_rst b0", 64'(y_b[31:0]),  64'd15200);
    chk("after_rst b1", 64'(y_b[63:32]), 64'hFFFFFFCE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
